clk_tick_gen: RTL and testbench
===============================

// Module: clk_tick_gen
// PURPOSE
//   Parametrised successor to the free-running clock divider. Keeps the WIDTH-bit free-running
//   count for display scanning, adds NCH independently programmable divide channels.
//   Each channel emits a one-cycle tick strobe and a square wave.
//   Sits beside the 7-seg/hex display and debounce logic as the shared timebase generator.
// PARAMETERS
//   WIDTH    32   width of free-running counter cnt
//   NCH      4    number of divide channels (1..16)
//   DIVW     16   width of per-channel divide register and channel counter
//   RST_DIV  999  divide value loaded into every channel at reset (tick period RST_DIV+1)
// PORTS
//   clk     in   1             system clock; single clock domain
//   rst     in   1             synchronous, active-high reset
//   en      in   1             global enable; 0 freezes every counter and output
//   cnt     out  WIDTH         free-running count
//   wrap    out  1             one-cycle pulse: cnt wrapped all-ones -> 0
//   wr_en   in   1             divide-register write strobe (single cycle)
//   wr_ch   in   CHW           target channel, CHW = max(1,$clog2(NCH))
//   wr_div  in   DIVW          new divide value D (tick period D+1)
//   ch_en   in   NCH           per-channel enable
//   tick    out  NCH           per-channel one-cycle strobe, registered
//   sq      out  NCH           per-channel square wave, toggles on each tick
// BEHAVIOUR
//   Reset (rst=1 at posedge clk): cnt=0, wrap=0, every ccnt=0, div=RST_DIV, tick=0, sq=0.
//     Reset overrides en, wr_en and ch_en.
//   Free-running counter, on enabled edge (en=1): cnt<=cnt+1 mod 2^WIDTH.
//     wrap<=1 iff cnt was all-ones; otherwise wrap<=0.
//   Channel c, on enabled edge, evaluated in priority order:
//     1 write hit (wr_en && wr_ch==c): div<=wr_div, ccnt<=0, tick<=0, sq unchanged.
//       The write wins over a coincident terminal count; no tick is issued that cycle.
//     2 ch_en[c]=0: ccnt<=0, tick<=0, sq<=0.
//     3 ccnt==div: ccnt<=0, tick<=1, sq<=~sq.
//     4 otherwise: ccnt<=ccnt+1, tick<=0.
//   Latency: from ccnt=0 with ch_en high, tick is visible after the (D+1)-th enabled edge.
//     Period is D+1 cycles. Square-wave period is 2(D+1) cycles, 50% duty.
//   D=0: tick held high every enabled cycle; sq toggles every cycle (clk/2).
//   en=0: all state holds, including cnt, ccnt, div and sq. tick<=0 and wrap<=0, so strobes
//     never stretch. Writes are ignored while en=0.
//   wr_ch >= NCH: write ignored, no state change.
//   Writes complete in one cycle; there is no handshake or back-pressure.
//   ccnt never exceeds div, so it never wraps. Comparison is equality on DIVW bits, unsigned.
//   Channels are fully independent; a write to one channel never disturbs another.
// STRUCTURE
//   Package clk_tick_pkg holds:
//     - CHW computation function
//     - default RST_DIV constant
//     - NCH_MAX=16 bound, checked by an elaboration-time assertion
//   Sub-module clk_tick_chan (DIVW, RST_DIV) holds div, ccnt, tick and sq for one channel.
//     Inputs: clk, rst, en, wr_hit, wr_div, ch_en.
//     Instantiated NCH times in a generate loop.
//   Top level contains the cnt/wrap register and the wr_ch decode.
// TESTING
//   1 Reset with RST_DIV=999, ch_en=all 1, en=1 -> tick[c] at edge 1000, 2000, ...;
//     sq[c] toggles at each tick; cnt==edge count.
//   2 Write wr_ch=1, wr_div=0 -> from next edge, tick[1]=1 every cycle and sq[1] toggles
//     every cycle; channels 0, 2, 3 unaffected.
//   3 Write wr_ch=2, wr_div=4 on the exact cycle ccnt2==div -> no tick that cycle;
//     next tick[2] 5 edges later, then every 5.
//   4 Drop en for 7 cycles mid-period -> tick, wrap=0 throughout; cnt, sq frozen;
//     phase resumes exactly (period counted over enabled edges only).
//   5 WIDTH=4: run 16 enabled edges -> wrap=1 exactly once, after the edge where cnt
//     goes 15 -> 0.
//   6 Assert rst mid-period with wr_en=1, wr_div=7 -> all outputs zero and div=RST_DIV;
//     the write is discarded; ch_en low -> sq=0, tick=0.

Source files
------------

// File: rtl/clk_tick_pkg.sv
// Shared constants and helpers for the tick generator and its channels.
package clk_tick_pkg;

    localparam int NCH_MAX     = 16;
    localparam int RST_DIV_DEF = 999;

    // Width of the channel-select field; at least one bit even for a single channel.
    function automatic int chw_of(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/clk_tick_chan.sv
// One divide channel: tick strobe every div+1 enabled cycles, square wave toggles per tick.
// Latency: tick registered, visible after the (div+1)-th enabled edge from ccnt=0.
// Backpressure: none; writes land in one cycle.
module clk_tick_chan
    import clk_tick_pkg::*;
#(
    parameter int DIVW    = 16,
    parameter int RST_DIV = RST_DIV_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            wr_hit,
    input  logic [DIVW-1:0] wr_div,
    input  logic            ch_en,
    output logic            tick,
    output logic            sq
);

    localparam logic [DIVW-1:0] RST_VAL = DIVW'(RST_DIV);

    logic [DIVW-1:0] div;
    logic [DIVW-1:0] ccnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= RST_VAL;
            ccnt <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (!en) begin
            // Everything holds; only the strobe is cleared so it never stretches.
            tick <= 1'b0;
        end else if (wr_hit) begin
            // A write beats a coincident terminal count and restarts the period.
            div  <= wr_div;
            ccnt <= '0;
            tick <= 1'b0;
        end else if (!ch_en) begin
            ccnt <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (ccnt == div) begin
            ccnt <= '0;
            tick <= 1'b1;
            sq   <= ~sq;
        end else begin
            ccnt <= ccnt + DIVW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_tick_gen.sv
// Shared timebase: free-running counter with wrap pulse plus NCH programmable tick channels.
// Latency: cnt/wrap/tick all registered, one cycle after the enabled edge that causes them.
// Backpressure: none; divide writes complete in one cycle, en=0 freezes all state.
module clk_tick_gen
    import clk_tick_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NCH     = 4,
    parameter int DIVW    = 16,
    parameter int RST_DIV = RST_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic [WIDTH-1:0]        cnt,
    output logic                    wrap,
    input  logic                    wr_en,
    input  logic [chw_of(NCH)-1:0]  wr_ch,
    input  logic [DIVW-1:0]         wr_div,
    input  logic [NCH-1:0]          ch_en,
    output logic [NCH-1:0]          tick,
    output logic [NCH-1:0]          sq
);

    localparam int CHW = chw_of(NCH);

    generate
        if (NCH < 1 || NCH > NCH_MAX) begin : g_nch_range
            $error("clk_tick_gen: NCH must be within 1..16");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            cnt  <= cnt + WIDTH'(1);
            wrap <= &cnt;
        end else begin
            wrap <= 1'b0;
        end
    end

    // Select values at or beyond NCH match no channel, so such writes vanish.
    logic [NCH-1:0] wr_hit;

    always_comb begin
        wr_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            wr_hit[c] = en && wr_en && (wr_ch == CHW'(c));
        end
    end

    genvar gc;
    generate
        for (gc = 0; gc < NCH; gc++) begin : g_chan
            clk_tick_chan #(
                .DIVW    (DIVW),
                .RST_DIV (RST_DIV)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .wr_hit  (wr_hit[gc]),
                .wr_div  (wr_div),
                .ch_en   (ch_en[gc]),
                .tick    (tick[gc]),
                .sq      (sq[gc])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_tick_gen.sv
// Scoreboard bench: expected tick/wrap events and state snapshots are queued by edge number.
module tb_clk_tick_gen;

    logic        clk = 1'b0;
    logic        rst, en, en4, wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic [3:0]  ch_en;

    logic [31:0] cnt;
    logic        wrap;
    logic [3:0]  tick, sq;
    logic [3:0]  cnt4;
    logic        wrap4;
    logic [3:0]  tick4, sq4;

    always #5 clk = ~clk;

    clk_tick_gen #(.WIDTH(32), .NCH(4), .DIVW(16), .RST_DIV(999)) dut (
        .clk(clk), .rst(rst), .en(en), .cnt(cnt), .wrap(wrap),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .ch_en(ch_en),
        .tick(tick), .sq(sq)
    );

    clk_tick_gen #(.WIDTH(4), .NCH(4), .DIVW(16), .RST_DIV(999)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .cnt(cnt4), .wrap(wrap4),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .ch_en(ch_en),
        .tick(tick4), .sq(sq4)
    );

    typedef struct {
        int e;
        bit s;
    } ev_t;

    typedef struct {
        int          e;
        logic [31:0] cnt;
        logic [3:0]  tick;
        logic [3:0]  sq;
        logic [3:0]  cnt4;
    } snap_t;

    // Event sources: 0..3 tick[c] (with sq after the tick), 4 wrap of dut4, 5 wrap of dut.
    ev_t   evq[6][$];
    snap_t snq[$];

    int edge_n = 0;
    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    always @(posedge clk) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    function automatic void pushev(input int src, input int e, input bit s);
        ev_t ev;
        ev.e = e;
        ev.s = s;
        evq[src].push_back(ev);
    endfunction

    function automatic void pushsnap(input int e, input logic [31:0] c, input logic [3:0] t,
                                     input logic [3:0] s, input logic [3:0] c4);
        snap_t sn;
        sn.e = e; sn.cnt = c; sn.tick = t; sn.sq = s; sn.cnt4 = c4;
        snq.push_back(sn);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    // Monitor: pops expected events whenever a strobe is seen, compares snapshots on their edge.
    always @(negedge clk) begin : monitor
        logic [5:0] act;
        ev_t        ex;
        snap_t      sn;
        if (done) begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (evq[k].size() != 0) begin
                    errors++;
                    $display("FAIL missed_events src=%0d: %0d left, expected 0", k, evq[k].size());
                end
            end
            checks++;
            if (snq.size() != 0) begin
                errors++;
                $display("FAIL missed_snapshots: %0d left, expected 0", snq.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else begin
            act = {wrap, wrap4, tick};
            for (int k = 0; k < 6; k++) begin
                if (act[k]) begin
                    if (evq[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event src=%0d at edge %0d: got 1 expected 0", k, edge_n);
                    end else begin
                        ex = evq[k].pop_front();
                        chk($sformatf("event_edge_src%0d", k), edge_n, ex.e);
                        chk($sformatf("event_sq_src%0d", k), (k < 4) ? {31'd0, sq[k]} : 32'd0, {31'd0, ex.s});
                    end
                end
            end
            if (snq.size() != 0 && snq[0].e == edge_n) begin
                sn = snq.pop_front();
                chk("snap_cnt", cnt, sn.cnt);
                chk("snap_tick", {28'd0, tick}, {28'd0, sn.tick});
                chk("snap_sq", {28'd0, sq}, {28'd0, sn.sq});
                chk("snap_cnt4", {28'd0, cnt4}, {28'd0, sn.cnt4});
            end
        end
    end

    task automatic to_edge(input int n);
        int g;
        g = 0;
        while (edge_n != n && g < 5000) begin
            @(negedge clk);
            g++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; en4 = 1'b1;
        wr_en = 1'b0; wr_ch = 2'd0; wr_div = 16'd0; ch_en = 4'hF;

        // Phase before the mid-run reset (edge numbers count from reset release).
        pushsnap(0,    32'd0,    4'h0,    4'h0,    4'd0);
        pushsnap(100,  32'd100,  4'h0,    4'h0,    4'd4);
        pushsnap(1000, 32'd1000, 4'hF,    4'hF,    4'd4);
        pushsnap(1010, 32'd1010, 4'b0010, 4'b1101, 4'd4);
        pushsnap(2025, 32'd2021, 4'h0,    4'b0100, 4'd4);
        pushsnap(2040, 32'd2033, 4'h0,    4'b0100, 4'd4);

        pushev(0, 1000, 1'b1); pushev(0, 2000, 1'b0); pushev(0, 3007, 1'b1);
        pushev(3, 1000, 1'b1); pushev(3, 2000, 1'b0); pushev(3, 3007, 1'b1);
        pushev(1, 1000, 1'b1);
        for (int e = 1006; e <= 1020; e++) pushev(1, e, bit'((e - 1006) % 2));
        pushev(2, 1000, 1'b1); pushev(2, 2005, 1'b0); pushev(2, 2010, 1'b1);
        pushev(2, 2015, 1'b0); pushev(2, 2020, 1'b1);
        for (int e = 2032; e <= 3009; e += 5) pushev(2, e, bit'(((e - 2032) / 5) % 2));
        pushev(4, 16, 1'b0);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        to_edge(20);   en4 = 1'b0;
        to_edge(1004); wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd0;
        to_edge(1005); wr_en = 1'b0;
        to_edge(1020); ch_en = 4'b1101;
        to_edge(1999); wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd4;
        to_edge(2000); wr_en = 1'b0;
        to_edge(2021); en = 1'b0;
        to_edge(2023); wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd3;
        to_edge(2024); wr_en = 1'b0;
        to_edge(2028); en = 1'b1;

        // Reset mid-period with a coincident write that must be discarded.
        to_edge(3009);
        pushsnap(0,    32'd0,    4'h0,    4'h0,    4'd0);
        pushsnap(1000, 32'd1000, 4'b1101, 4'b1101, 4'd0);
        pushev(0, 1000, 1'b1); pushev(2, 1000, 1'b1); pushev(3, 1000, 1'b1);
        rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd7;
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;

        to_edge(1005);
        done = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL monitor_stuck: summary not reached, expected finish");
        $fatal(1);
    end

endmodule
